pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Program-counter sequencer for the pipelined core. It owns the PC register and consumes the taken/target decision produced in EX by the jump/branch unit. From that decision it generates the IF/ID and ID/EX flush strobes, honours load-use stalls from the hazard unit, and traps misaligned or out-of-range jump targets. It sits between the jump/branch unit, the hazard unit and the instruction-memory address port, and keeps saturating redirect/stall counters for performance debug.

## Interface
- PC_W, 9, width of the PC and instruction-memory address
- RESET_PC, 0, PC value loaded on reset
- TRAP_VEC, 9'h1F0, PC loaded when a trap is acknowledged; must be word-aligned
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Stall  in  1  load-use hazard from hazard unit: hold PC and IF/ID
- Ex_Valid  in  1  EX stage holds a real (non-bubble) instruction
- PcSel  in  1  branch/jump taken, from jump/branch unit
- BrPC  in  32  redirect target, from jump/branch unit
- Trap_Ack  in  1  trap handler acceptance, single-cycle pulse
- PC  out  PC_W  current fetch address, registered
- Flush_IFID  out  1  squash IF/ID register at next edge (combinational)
- Flush_IDEX  out  1  squash ID/EX register at next edge, i.e. insert bubble (combinational)
- Trap_Req  out  1  bad-target trap pending, registered
- Trap_PC  out  32  offending BrPC, registered
- Redirect_Cnt  out  16  accepted redirects, saturating
- Stall_Cnt  out  16  stall cycles honoured, saturating

## Operation
- Redirect condition: Redir = Ex_Valid && PcSel. PcSel without Ex_Valid is ignored.
- Bad target: BrPC[1:0] != 0, or BrPC[31:PC_W] != 0.
- FSM has two states: RUN and TRAP. Reset puts it in RUN.
- RUN, per-cycle priority (highest first):
  1. **Redir with bad target:** Flush_IFID=1, Flush_IDEX=1. PC holds. Trap_Req<=1, Trap_PC<=BrPC. Go to TRAP. Counters unchanged.
  2. **Redir with good target:** Flush_IFID=1, Flush_IDEX=1. PC<=BrPC[PC_W-1:0]. Redirect_Cnt increments. A simultaneous Stall is overridden and not counted.
  3. **Stall:** PC holds. Flush_IFID=0, Flush_IDEX=1 (bubble). Stall_Cnt increments.
  4. **Otherwise:** PC<=PC+4, truncated to PC_W bits, so the PC wraps 2^PC_W-4 -> 0. No flushes.
- TRAP:
  - Flush_IFID=1 and Flush_IDEX=1 every cycle. PC holds. Stall, PcSel and Ex_Valid are ignored. Counters frozen.
  - On Trap_Ack: PC<=TRAP_VEC, Trap_Req<=0, go to RUN. Trap_PC keeps its value until the next trap.
  - Trap_Ack while in RUN has no effect.
- Counters saturate at 16'hFFFF and never wrap.
- While reset=1: Flush_IFID=1 and Flush_IDEX=1. At the edge, PC<=RESET_PC, Trap_Req<=0, Trap_PC<=0, both counters <=0, state<=RUN. Reset mid-TRAP abandons the trap with no acknowledge required.

## Timing
- Redirect latency: Redir sampled in cycle N; PC=target in cycle N+1.
- Branch penalty is 2 instructions (the ones in IF and ID at cycle N), squashed by the flushes at the N->N+1 edge.
- Stall: PC holds for exactly as many cycles as Stall is high. Sequential fetch resumes the cycle after Stall drops.
- Trap: Trap_Req rises at N+1 after a bad Redir at N. With Trap_Ack at cycle M, PC=TRAP_VEC and Trap_Req=0 at M+1.
- Back-to-back redirects in consecutive cycles are each accepted. Ex_Valid is normally 0 the cycle after a redirect because ID/EX was flushed; the block does not rely on this.
- Flush outputs depend combinationally on inputs and state only. PC, Trap_Req, Trap_PC and the counters are registered.

## Test plan
- **Reset and sequential fetch:** release reset with no stimulus -> PC = 0, 4, 8, …; at PC=0x1FC the next PC=0x000; flushes 0; counters 0.
- **Taken branch:** Ex_Valid=1, PcSel=1, BrPC=0x40 at PC=0x10 -> Flush_IFID=Flush_IDEX=1 that cycle; next PC=0x40; Redirect_Cnt=1.
- **Stall vs redirect:** Stall=1 for 3 cycles at PC=0x20 -> PC held at 0x20 with Flush_IDEX=1 and Flush_IFID=0, Stall_Cnt=3, next PC=0x24. Repeat with Stall=1 and Redir (BrPC=0x80) together -> PC=0x80, Stall_Cnt unchanged.
- **Ignored PcSel:** PcSel=1, BrPC=0x80, Ex_Valid=0 -> no flush, PC+4.
- **Misaligned trap:** Redir with BrPC=0x42 -> Trap_Req=1, Trap_PC=0x42, PC frozen and flushes high for 5 cycles; Trap_Ack pulse -> next PC=0x1F0, Trap_Req=0. Out-of-range BrPC=0x200 -> same trap path. Reset asserted mid-TRAP -> PC=0, Trap_Req=0.
- **Saturation:** force 65 537 accepted redirects -> Redirect_Cnt stays at 0xFFFF.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Program-counter sequencer for the pipelined core. Owns the PC register,
// applies taken branch/jump redirects resolved in EX, honours load-use stalls,
// and traps redirects whose target is misaligned or beyond the PC range.
// Keeps saturating redirect / stall counters for performance debug.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         synchronous active-high reset
//   Stall         load-use hazard: hold PC and IF/ID, bubble ID/EX
//   Ex_Valid      EX holds a real (non-bubble) instruction
//   PcSel         branch/jump taken
//   BrPC          redirect target
//   Trap_Ack      trap handler acceptance pulse
//   PC            current fetch address (registered)
//   Flush_IFID    squash IF/ID at next edge (combinational)
//   Flush_IDEX    squash ID/EX at next edge (combinational)
//   Trap_Req      bad-target trap pending (registered)
//   Trap_PC       offending target of the last trap (registered)
//   Redirect_Cnt  accepted redirects, saturating
//   Stall_Cnt     honoured stall cycles, saturating
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'('h1F0)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            Ex_Valid,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Trap_Ack,
    output logic [PC_W-1:0] PC,
    output logic            Flush_IFID,
    output logic            Flush_IDEX,
    output logic            Trap_Req,
    output logic [31:0]     Trap_PC,
    output logic [15:0]     Redirect_Cnt,
    output logic [15:0]     Stall_Cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    localparam int CNT_REDIR = 0;
    localparam int CNT_STALL = 1;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic              trap_req_reg, trap_req_next;
    logic [31:0]       trap_pc_reg, trap_pc_next;
    logic [15:0]       cnt_reg [2];
    logic [1:0]        cnt_inc;
    logic              flush_ifid, flush_idex;

    logic redir;
    logic bad_target;

    assign redir      = Ex_Valid & PcSel;
    // Targets must be word aligned and fit inside the PC address space.
    assign bad_target = (BrPC[1:0] != 2'b00) || (BrPC[31:PC_W] != '0);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (redir && bad_target) begin
                    state_next = TRAP;
                end
            end
            TRAP: begin
                if (Trap_Ack) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        pc_next       = pc_reg;
        trap_req_next = trap_req_reg;
        trap_pc_next  = trap_pc_reg;
        cnt_inc       = 2'b00;
        case (state_reg)
            RUN: begin
                if (redir) begin
                    // A redirect overrides any simultaneous stall.
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (bad_target) begin
                        trap_req_next = 1'b1;
                        trap_pc_next  = BrPC;
                    end else begin
                        pc_next            = BrPC[PC_W-1:0];
                        cnt_inc[CNT_REDIR] = 1'b1;
                    end
                end else if (Stall) begin
                    flush_idex         = 1'b1;
                    cnt_inc[CNT_STALL] = 1'b1;
                end else begin
                    pc_next = pc_reg + PC_W'(4);
                end
            end
            TRAP: begin
                // Pipeline is kept empty until the handler accepts the trap.
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                if (Trap_Ack) begin
                    pc_next       = TRAP_VEC;
                    trap_req_next = 1'b0;
                end
            end
            default: ;
        endcase
        if (reset) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

    // ---------------------------------------------------------------- datapath regs
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            trap_req_reg <= 1'b0;
            trap_pc_reg  <= '0;
        end else begin
            pc_reg       <= pc_next;
            trap_req_reg <= trap_req_next;
            trap_pc_reg  <= trap_pc_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign PC           = pc_reg;
    assign Flush_IFID   = flush_ifid;
    assign Flush_IDEX   = flush_idex;
    assign Trap_Req     = trap_req_reg;
    assign Trap_PC      = trap_pc_reg;
    assign Redirect_Cnt = cnt_reg[CNT_REDIR];
    assign Stall_Cnt    = cnt_reg[CNT_STALL];

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed scenarios followed by randomized stimulus, all compared against a
// cycle-level behavioural model of the PC sequencer kept in plain integers.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    localparam int PC_W     = 9;
    localparam int PC_SPAN  = 1 << PC_W;
    localparam int TRAP_VEC = 'h1F0;

    logic            clk;
    logic            reset;
    logic            Stall;
    logic            Ex_Valid;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            Trap_Ack;
    logic [PC_W-1:0] PC;
    logic            Flush_IFID;
    logic            Flush_IDEX;
    logic            Trap_Req;
    logic [31:0]     Trap_PC;
    logic [15:0]     Redirect_Cnt;
    logic [15:0]     Stall_Cnt;

    pc_redirect_ctrl #(
        .PC_W     (PC_W),
        .RESET_PC (9'h000),
        .TRAP_VEC (9'h1F0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .Ex_Valid     (Ex_Valid),
        .PcSel        (PcSel),
        .BrPC         (BrPC),
        .Trap_Ack     (Trap_Ack),
        .PC           (PC),
        .Flush_IFID   (Flush_IFID),
        .Flush_IDEX   (Flush_IDEX),
        .Trap_Req     (Trap_Req),
        .Trap_PC      (Trap_PC),
        .Redirect_Cnt (Redirect_Cnt),
        .Stall_Cnt    (Stall_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_pc      = 0;
    bit          m_trap    = 0;
    int unsigned m_trap_pc = 0;
    int unsigned m_rc      = 0;
    int unsigned m_sc      = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit st, input bit ev, input bit ps,
                         input logic [31:0] br, input bit ack);
        reset    = rst;
        Stall    = st;
        Ex_Valid = ev;
        PcSel    = ps;
        BrPC     = br;
        Trap_Ack = ack;
    endtask

    // One clock cycle: check flushes for the current inputs, advance the
    // model by the sequencing rules, then check the registered outputs.
    task automatic step(input bit chk);
        bit          e_fi, e_fd;
        bit          redir, bad;
        int unsigned br;
        #1;
        br    = BrPC;
        redir = Ex_Valid && PcSel;
        bad   = (br % 4 != 0) || (br >= PC_SPAN);
        e_fi  = 0;
        e_fd  = 0;
        if (reset) begin
            e_fi = 1; e_fd = 1;
            m_pc = 0; m_trap = 0; m_trap_pc = 0; m_rc = 0; m_sc = 0;
        end else if (m_trap) begin
            e_fi = 1; e_fd = 1;
            if (Trap_Ack) begin
                m_pc   = TRAP_VEC;
                m_trap = 0;
            end
        end else if (redir && bad) begin
            e_fi = 1; e_fd = 1;
            m_trap    = 1;
            m_trap_pc = br;
        end else if (redir) begin
            e_fi = 1; e_fd = 1;
            m_pc = br;
            if (m_rc < 65535) m_rc++;
        end else if (Stall) begin
            e_fd = 1;
            if (m_sc < 65535) m_sc++;
        end else begin
            m_pc = (m_pc + 4) % PC_SPAN;
        end
        if (chk) begin
            check_val("flush_ifid", 32'(Flush_IFID), 32'(e_fi));
            check_val("flush_idex", 32'(Flush_IDEX), 32'(e_fd));
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check_val("pc",           32'(PC),           m_pc);
            check_val("trap_req",     32'(Trap_Req),     32'(m_trap));
            check_val("trap_pc",      Trap_PC,           m_trap_pc);
            check_val("redirect_cnt", 32'(Redirect_Cnt), m_rc);
            check_val("stall_cnt",    32'(Stall_Cnt),    m_sc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 32'h0, 0);
            step(1);
        end
    endtask

    initial begin
        logic [31:0] br;

        // Reset and sequential fetch
        drive(1, 0, 0, 0, 32'h0, 0);
        step(1);
        step(1);
        check_val("reset_pc", 32'(PC), 32'h0);
        check_val("reset_cnt", 32'(Redirect_Cnt) + 32'(Stall_Cnt), 32'h0);
        idle(4);
        check_val("seq_pc_0x10", 32'(PC), 32'h10);

        // Taken branch at PC=0x10
        drive(0, 0, 1, 1, 32'h40, 0);
        #1;
        check_val("br_flush_both", {30'h0, Flush_IFID, Flush_IDEX}, 32'h3);
        step(1);
        check_val("br_target", 32'(PC), 32'h40);
        check_val("br_cnt", 32'(Redirect_Cnt), 32'h1);

        // Stall for 3 cycles at 0x20
        drive(0, 0, 1, 1, 32'h20, 0);
        step(1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 32'h0, 0);
            step(1);
            check_val("stall_hold", 32'(PC), 32'h20);
        end
        check_val("stall_cnt3", 32'(Stall_Cnt), 32'h3);
        idle(1);
        check_val("stall_resume", 32'(PC), 32'h24);

        // Stall together with redirect: redirect wins
        drive(0, 1, 1, 1, 32'h80, 0);
        step(1);
        check_val("stall_redir_pc", 32'(PC), 32'h80);
        check_val("stall_redir_sc", 32'(Stall_Cnt), 32'h3);

        // PcSel without Ex_Valid is ignored
        drive(0, 0, 0, 1, 32'h100, 0);
        step(1);
        check_val("ignored_pcsel", 32'(PC), 32'h84);

        // Misaligned target -> trap, frozen for 5 cycles with noise
        drive(0, 0, 1, 1, 32'h42, 0);
        step(1);
        check_val("trap_req_set", 32'(Trap_Req), 32'h1);
        check_val("trap_pc_42", Trap_PC, 32'h42);
        for (int i = 0; i < 5; i++) begin
            drive(0, i[0], 1, 1, 32'h10, 0);
            step(1);
            check_val("trap_frozen", 32'(PC), 32'h84);
        end
        drive(0, 0, 0, 0, 32'h0, 1);
        step(1);
        check_val("trap_vec", 32'(PC), 32'h1F0);
        check_val("trap_cleared", 32'(Trap_Req), 32'h0);

        // Out-of-range target -> trap, ack
        drive(0, 0, 1, 1, 32'h200, 0);
        step(1);
        idle(2);
        drive(0, 0, 0, 0, 32'h0, 1);
        step(1);
        check_val("trap2_vec", 32'(PC), 32'h1F0);

        // Reset in the middle of a trap
        drive(0, 0, 1, 1, 32'h42, 0);
        step(1);
        idle(2);
        drive(1, 0, 0, 0, 32'h0, 0);
        step(1);
        check_val("rst_trap_pc", 32'(PC), 32'h0);
        check_val("rst_trap_req", 32'(Trap_Req), 32'h0);

        // PC wrap 0x1FC -> 0x000
        drive(0, 0, 1, 1, 32'h1F8, 0);
        step(1);
        idle(1);
        check_val("wrap_pre", 32'(PC), 32'h1FC);
        idle(1);
        check_val("wrap_zero", 32'(PC), 32'h0);

        // Randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       br = $urandom_range(0, PC_SPAN - 1);
                1:       br = $urandom;
                default: br = $urandom_range(0, PC_SPAN / 4 - 1) * 4;
            endcase
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 3),
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0,
                  br,
                  ($urandom_range(0, 3) == 0));
            step(1);
        end

        // Redirect counter saturation
        drive(1, 0, 0, 0, 32'h0, 0);
        step(1);
        drive(0, 0, 1, 1, 32'h40, 0);
        for (int i = 0; i < 65537; i++) begin
            step(0);
        end
        step(1);
        check_val("rc_saturated", 32'(Redirect_Cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
